char_pos_ctrl: RTL
==================

// Module: char_pos_ctrl
// PURPOSE
// - Sequences the character-window datapath: owns posHorStart/End, posVerStart/End and flashClk.
// - Moves the glyph window from four debounced direction buttons.
// - Applies every change only at the frame boundary, so a frame never shows a torn window.
// - Wraps at screen edges, giving Start > End (the split window the datapath already draws).
// - Sits between the button debouncers / VGA timing counters and the char datapath.
// PARAMETERS
// - H_ACTIVE      640  active pixels per line (`HDR in globalVariables.v)
// - V_ACTIVE      480  active lines per frame (`VDR)
// - CHAR_W        8    glyph width in pixels
// - CHAR_H        16   glyph height in lines
// - STEP          1    pixels/lines moved per step; 1 <= STEP < min(CHAR_W, CHAR_H)
// - REPEAT_DELAY  20   frames a button is held before auto-repeat starts
// - REPEAT_RATE   4    frames between auto-repeat steps
// - FLASH_FRAMES  30   frames per flashClk half-period
// PORTS
// - clock        in   1   pixel clock; pixelCnt/lineCnt advance once per clock
// - reset        in   1   reset, asynchronous, active-high
// - pixelCnt     in   10  current pixel in line
// - lineCnt      in   9   current line in frame
// - btnUp/btnDown/btnLeft/btnRight  in 1 each   debounced, level, synchronous to clock
// - flashEn      in   1   1 = glyph blinks
// - posHorStart  out  10  first window column, 0..H_ACTIVE-1
// - posHorEnd    out  10  (posHorStart+CHAR_W) mod H_ACTIVE
// - posVerStart  out  9   first window line, 0..V_ACTIVE-1
// - posVerEnd    out  9   (posVerStart+CHAR_H) mod V_ACTIVE
// - flashClk     out  1   1 = glyph blanked this frame
// - moving       out  1   1 while any axis is in FIRST or REPEAT state
// BEHAVIOUR
// - Reset values: posHorStart=316, posHorEnd=324, posVerStart=232, posVerEnd=248, flashClk=0, moving=0.
// - Reset clears all frame counters; both axis FSMs go to IDLE. Reset mid-move abandons the step.
// - frameTick: 1-cycle pulse on the first clock where lineCnt==V_ACTIVE && pixelCnt==0.
//   - Implemented as a rising-edge detect of that compare, so a stalled counter gives one tick only.
// - Each axis resolves its buttons as follows:
//   - dir=+1 for down/right only; dir=-1 for up/left only.
//   - Both or neither pressed: no request on that axis.
// - Axis FSM states IDLE, FIRST, REPEAT. Transitions are evaluated only on frameTick:
//   - IDLE -> FIRST when a request is present; apply one step; holdCnt=0.
//   - FIRST: request still held -> holdCnt++. When holdCnt reaches REPEAT_DELAY-1: step, go to REPEAT, rptCnt=0.
//   - REPEAT: request held -> rptCnt++. When rptCnt reaches REPEAT_RATE-1: step, rptCnt=0.
//   - FIRST/REPEAT: request gone, or direction changed -> IDLE with no step. A new direction starts at the next tick.
// - Step arithmetic (Start): +STEP -> Start+STEP >= RANGE ? Start+STEP-RANGE : Start+STEP.
//   - -STEP -> Start >= STEP ? Start-STEP : Start+RANGE-STEP.
// - End is recomputed in the same cycle with the same modulo rule, so Start/End always update together.
// - Intermediate sums are 1 bit wider than the output; no truncation before the compare.
// - Outputs are registered and change only in the cycle after frameTick, i.e. while lineCnt==V_ACTIVE.
// - Both axes may step on the same tick.
// - Flash:
//   - flashEn=1: frame counter counts ticks; flashClk toggles when the count reaches FLASH_FRAMES-1, and the count clears.
//   - flashEn=0: flashClk=0 and the counter is held at 0.
//   - flashEn rising: the first toggle comes FLASH_FRAMES ticks later.
// - moving is combinational OR of (axis state != IDLE) over both axes.
// STRUCTURE
// - Constants HDR/VDR/CHAR_W/CHAR_H and the state encoding (IDLE=2'd0, FIRST=2'd1, REPEAT=2'd2) go in globalVariables.v.
// - One sub-module, pos_axis_ctrl, instantiated twice:
//   - params RANGE, SIZE, WIDTH, STEP, REPEAT_DELAY, REPEAT_RATE.
//   - ports clock, reset, frameTick, incReq, decReq, posStart, posEnd, active.
// - The top level holds the frameTick detect, the flash counter and the button-to-axis mapping.
// TESTING
// - Reset, then run 1 frame with no buttons -> 316/324/232/248 held; flashClk=0; moving=0.
// - btnRight held 1 frame -> after tick posHorStart=317, End=325.
//   - Held 25 frames -> steps on ticks 1, 21, 25; Start=319.
// - Force posHorStart=636 via repeated right -> next step gives Start=637, End=5 (Start>End).
//   - Left from Start=0 -> Start=639, End=7.
// - btnUp+btnDown together for 10 frames -> vertical unchanged, moving=0.
//   - btnUp+btnLeft together -> both axes step on the same tick.
// - flashEn=1 for 90 frames -> flashClk toggles at ticks 30, 60, 90.
//   - Drop flashEn -> flashClk=0 next cycle.
// - Assert reset in FIRST with holdCnt=10 -> outputs return to reset values; moving=0.
//   - After release, a held button steps on the first tick.

Source files
------------

// File: rtl/char_pos_ctrl_pkg.sv
// Shared constants and the axis state encoding for the character-window position controller.
package char_pos_ctrl_pkg;

    localparam int HDR     = 640;
    localparam int VDR     = 480;
    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        REPEAT = 2'd2
    } axisState_t;

    // Bits needed for a counter that runs 0..n-1 (at least one bit).
    function automatic int ctrWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pos_axis_ctrl.sv
// One axis of the glyph window: button hold/auto-repeat FSM plus wrapping Start/End registers.
module pos_axis_ctrl
    import char_pos_ctrl_pkg::*;
#(
    parameter int RANGE        = 640,
    parameter int SIZE         = 8,
    parameter int WIDTH        = 10,
    parameter int STEP         = 1,
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             frameTick,
    input  logic             incReq,
    input  logic             decReq,
    output logic [WIDTH-1:0] posStart,
    output logic [WIDTH-1:0] posEnd,
    output logic             active
);

    localparam int WW = WIDTH + 1;
    localparam int HW = ctrWidth(REPEAT_DELAY);
    localparam int RW = ctrWidth(REPEAT_RATE);

    localparam logic [WW-1:0] RANGE_W = WW'(RANGE);
    localparam logic [WW-1:0] STEP_W  = WW'(STEP);
    localparam logic [WW-1:0] SIZE_W  = WW'(SIZE);

    localparam logic [WIDTH-1:0] RST_START = WIDTH'(RANGE / 2 - SIZE / 2);
    localparam logic [WIDTH-1:0] RST_END   = WIDTH'((RANGE / 2 - SIZE / 2 + SIZE) % RANGE);

    localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_RATE - 1);

    axisState_t    state;
    logic          lastInc;
    logic [HW-1:0] holdCnt;
    logic [RW-1:0] rptCnt;

    logic          req;
    logic [WW-1:0] startW;
    logic [WW-1:0] sumInc;
    logic [WW-1:0] endSum;
    logic [WW-1:0] nextStartW;
    logic [WW-1:0] nextEndW;

    // Exactly one button of the pair forms a request; both cancel out.
    assign req    = incReq ^ decReq;
    assign active = (state != IDLE);

    // Sums are one bit wider than the position so the wrap compare sees the carry.
    always_comb begin
        startW = {1'b0, posStart};
        sumInc = startW + STEP_W;
        if (incReq) begin
            nextStartW = (sumInc >= RANGE_W) ? sumInc - RANGE_W : sumInc;
        end else begin
            nextStartW = (startW >= STEP_W) ? startW - STEP_W : startW + RANGE_W - STEP_W;
        end
        endSum   = nextStartW + SIZE_W;
        nextEndW = (endSum >= RANGE_W) ? endSum - RANGE_W : endSum;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lastInc  <= 1'b0;
            holdCnt  <= '0;
            rptCnt   <= '0;
            posStart <= RST_START;
            posEnd   <= RST_END;
        end else if (frameTick) begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state    <= FIRST;
                        lastInc  <= incReq;
                        holdCnt  <= '0;
                        posStart <= nextStartW[WIDTH-1:0];
                        posEnd   <= nextEndW[WIDTH-1:0];
                    end
                end
                FIRST: begin
                    if (!req || (incReq != lastInc)) begin
                        state <= IDLE;
                    end else if (holdCnt == HOLD_LAST) begin
                        state    <= REPEAT;
                        rptCnt   <= '0;
                        posStart <= nextStartW[WIDTH-1:0];
                        posEnd   <= nextEndW[WIDTH-1:0];
                    end else begin
                        holdCnt <= holdCnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!req || (incReq != lastInc)) begin
                        state <= IDLE;
                    end else if (rptCnt == RPT_LAST) begin
                        rptCnt   <= '0;
                        posStart <= nextStartW[WIDTH-1:0];
                        posEnd   <= nextEndW[WIDTH-1:0];
                    end else begin
                        rptCnt <= rptCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/char_pos_ctrl.sv
// Glyph-window sequencer: frame-boundary tick, flash timing and button-to-axis mapping.
module char_pos_ctrl
    import char_pos_ctrl_pkg::*;
#(
    parameter int H_ACTIVE     = HDR,
    parameter int V_ACTIVE     = VDR,
    parameter int CHAR_W       = GLYPH_W,
    parameter int CHAR_H       = GLYPH_H,
    parameter int STEP         = 1,
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 4,
    parameter int FLASH_FRAMES = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] pixelCnt,
    input  logic [8:0] lineCnt,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic       flashEn,
    output logic [9:0] posHorStart,
    output logic [9:0] posHorEnd,
    output logic [8:0] posVerStart,
    output logic [8:0] posVerEnd,
    output logic       flashClk,
    output logic       moving
);

    localparam int FW = ctrWidth(FLASH_FRAMES);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);

    logic          frameHit;
    logic          frameHitPrev;
    logic          frameTick;
    logic [FW-1:0] flashCnt;
    logic          horActive;
    logic          verActive;

    // Edge-detect the blanking compare so a stalled counter yields a single tick.
    assign frameHit  = (lineCnt == 9'(V_ACTIVE)) && (pixelCnt == 10'd0);
    assign frameTick = frameHit && !frameHitPrev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frameHitPrev <= 1'b0;
        end else begin
            frameHitPrev <= frameHit;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flashCnt <= '0;
            flashClk <= 1'b0;
        end else if (!flashEn) begin
            flashCnt <= '0;
            flashClk <= 1'b0;
        end else if (frameTick) begin
            if (flashCnt == FLASH_LAST) begin
                flashCnt <= '0;
                flashClk <= ~flashClk;
            end else begin
                flashCnt <= flashCnt + 1'b1;
            end
        end
    end

    pos_axis_ctrl #(
        .RANGE       (H_ACTIVE),
        .SIZE        (CHAR_W),
        .WIDTH       (10),
        .STEP        (STEP),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) horAxis (
        .clock    (clock),
        .reset    (reset),
        .frameTick(frameTick),
        .incReq   (btnRight),
        .decReq   (btnLeft),
        .posStart (posHorStart),
        .posEnd   (posHorEnd),
        .active   (horActive)
    );

    pos_axis_ctrl #(
        .RANGE       (V_ACTIVE),
        .SIZE        (CHAR_H),
        .WIDTH       (9),
        .STEP        (STEP),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) verAxis (
        .clock    (clock),
        .reset    (reset),
        .frameTick(frameTick),
        .incReq   (btnDown),
        .decReq   (btnUp),
        .posStart (posVerStart),
        .posEnd   (posVerEnd),
        .active   (verActive)
    );

    assign moving = horActive | verActive;

endmodule
